v60_regfile_mp: RTL
===================

V60_REGFILE_MP -- requirements
Module: v60_regfile_mp

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 32, meaning register width in bits (multiple of 8).
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning number of registers (2..64).
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(NUM_REGS), meaning register address width.
REQ-004 The block SHALL have ports clk input 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports raddr1, raddr2 input ADDR_W each, read addresses.
REQ-007 The block SHALL have ports rdata1, rdata2 output REG_WIDTH each, read data.
REQ-008 The block SHALL have ports rbusy1, rbusy2 output 1 each, pending-write flag of raddr1/raddr2.
REQ-009 The block SHALL have ports wen0 input 1, waddr0 input ADDR_W, wdata0 input REG_WIDTH, wbe0 input REG_WIDTH/8; these form the execute write port.
REQ-010 The block SHALL have ports wen1 input 1, waddr1 input ADDR_W, wdata1 input REG_WIDTH, wbe1 input REG_WIDTH/8; these form the load/writeback write port.
REQ-011 The block SHALL have ports bset input 1 and baddr input ADDR_W, which mark a register as pending.
REQ-012 The block SHALL have port busy_cnt output $clog2(NUM_REGS+1), the number of pending registers.

Function
REQ-013 Reads SHALL be combinational: rdata = stored register value; rbusy = busy bit.
REQ-014 A write SHALL update only the byte lanes whose wbe bit is 1; other lanes hold their value.
REQ-015 Same-cycle writes from both ports to the same address SHALL merge per lane: port 1 wins in lanes where wbe1=1; port 0 supplies lanes with only wbe0=1.
REQ-016 The busy bit SHALL be set at the edge where bset=1, for register baddr.
REQ-017 The busy bit SHALL be cleared at the edge where wen1=1, for register waddr1, including when wbe1=0.
REQ-018 A port 0 write SHALL never change any busy bit.
REQ-019 If bset and the wen1 clear hit the same register in one cycle, the set SHALL win and the bit ends as 1.
REQ-020 A bset to an already-busy register SHALL leave the register busy and busy_cnt unchanged.
REQ-021 busy_cnt SHALL be registered and always equal the population count of the busy bits after each edge.
REQ-022 Any address >= NUM_REGS SHALL be ignored for writes and bset; reads of such an address SHALL return 0 with rbusy=0.
REQ-023 Write latency SHALL be 1 cycle: data is visible on reads in the cycle after the write edge.

Reset
REQ-024 While rst_n=0, all registers, all busy bits and busy_cnt SHALL be 0, independent of clk.
REQ-025 On reset, rdata1/rdata2 SHALL read 0 and rbusy1/rbusy2 SHALL be 0.
REQ-026 Writes or bset in progress when reset asserts SHALL be discarded.
REQ-027 Normal operation SHALL resume at the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 Macro V60_REGFILE_BYPASS_EN SHALL enable write-to-read forwarding.
REQ-029 With V60_REGFILE_BYPASS_EN defined, a read whose address matches an active same-cycle write SHALL return the lane-merged next value per REQ-014/015. rbusy SHALL then read 0 when the clearing wen1 targets that address and bset does not.
REQ-030 With V60_REGFILE_BYPASS_EN undefined, reads SHALL return pre-edge storage and busy values only.

Verification
REQ-031 Reset, then read all addresses -> rdata=0, rbusy=0, busy_cnt=0.
REQ-032 wen0 to r5 with 32'h11223344 and wbe0=4'b1111, then wen0 to r5 with 32'hAABBCCDD and wbe0=4'b0101 -> r5 reads 32'h11BB33DD.
REQ-033 Same cycle: wen0 to r7 with 32'h00000000 and wbe0=4'b1111, plus wen1 to r7 with 32'hFFFFFFFF and wbe1=4'b0011 -> r7=32'h0000FFFF.
REQ-034 bset r3, then bset r9 -> busy_cnt=2, rbusy(r3)=1. Then same cycle bset r3 plus wen1 to r3 -> r3 stays busy and busy_cnt=2. Then wen1 to r9 with wbe1=0 -> busy_cnt=1 and r9 data unchanged.
REQ-035 With bypass enabled: wen1 to r2 with 32'hDEADBEEF, r2 busy, raddr1=2 in the same cycle -> rdata1=32'hDEADBEEF and rbusy1=0 in that cycle. With bypass disabled -> old data and rbusy1=1.
REQ-036 With NUM_REGS=24: write to address 30, and bset to address 30 -> no register changes, busy_cnt unchanged, and a read of address 30 returns 0.

Source files
------------

// File: rtl/v60_regfile_mp.sv
// v60_regfile_mp: multi-port register file with byte-lane writes and
// per-register pending (busy) tracking for scoreboarding.
//
// Parameters:
//   REG_WIDTH  register width in bits (multiple of 8), default 32
//   NUM_REGS   number of registers (2..64), default 32
//   ADDR_W     register address width, default $clog2(NUM_REGS)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   raddr1/2 -> rdata1/2  combinational read data
//   rbusy1/2              pending flag of the addressed register
//   wen0/waddr0/wdata0/wbe0  execute write port (never touches busy bits)
//   wen1/waddr1/wdata1/wbe1  writeback port; also clears the busy bit of
//                            waddr1, even when wbe1 is all zero
//   bset/baddr            marks register baddr as pending
//   busy_cnt              registered count of pending registers
//
// Addresses >= NUM_REGS are ignored for writes and bset, and read as 0.
//
// Build option:
//   V60_REGFILE_BYPASS_EN  forward same-cycle writes (and busy clears)
//                          to the read ports. Undefined: reads return
//                          pre-edge storage only.

module v60_regfile_mp #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic [ADDR_W-1:0]                  raddr1,
    input  logic [ADDR_W-1:0]                  raddr2,
    output logic [REG_WIDTH-1:0]               rdata1,
    output logic [REG_WIDTH-1:0]               rdata2,
    output logic                               rbusy1,
    output logic                               rbusy2,

    input  logic                               wen0,
    input  logic [ADDR_W-1:0]                  waddr0,
    input  logic [REG_WIDTH-1:0]               wdata0,
    input  logic [REG_WIDTH/8-1:0]             wbe0,

    input  logic                               wen1,
    input  logic [ADDR_W-1:0]                  waddr1,
    input  logic [REG_WIDTH-1:0]               wdata1,
    input  logic [REG_WIDTH/8-1:0]             wbe1,

    input  logic                               bset,
    input  logic [ADDR_W-1:0]                  baddr,

    output logic [$clog2(NUM_REGS+1)-1:0]      busy_cnt
);

    localparam int NB = REG_WIDTH / 8;
    localparam int CW = $clog2(NUM_REGS + 1);

    logic [REG_WIDTH-1:0] mem     [NUM_REGS];
    logic [REG_WIDTH-1:0] mem_nxt [NUM_REGS];

    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  busy_nxt;

    // One-hot decode of each write/set address. Out-of-range
    // addresses match no entry, so they are dropped here.
    logic [NUM_REGS-1:0]  hit0;
    logic [NUM_REGS-1:0]  hit1;
    logic [NUM_REGS-1:0]  hitb;

    logic [CW-1:0]        cnt_nxt;

    always_comb begin
        hit0 = '0;
        hit1 = '0;
        hitb = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit0[i] = wen0 && (waddr0 == ADDR_W'(i));
            hit1[i] = wen1 && (waddr1 == ADDR_W'(i));
            hitb[i] = bset && (baddr == ADDR_W'(i));
        end
    end

    // Lane merge: port 1 owns any lane it enables, port 0 fills
    // the lanes only it enables, untouched lanes hold.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_nxt[i] = mem[i];
            for (int b = 0; b < NB; b++) begin
                if (hit1[i] && wbe1[b]) begin
                    mem_nxt[i][8*b +: 8] = wdata1[8*b +: 8];
                end else if (hit0[i] && wbe0[b]) begin
                    mem_nxt[i][8*b +: 8] = wdata0[8*b +: 8];
                end
            end
        end
    end

    // Set beats clear on a same-register collision.
    assign busy_nxt = hitb | (busy & ~hit1);

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= mem_nxt[i];
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Read ports. The mux is a compare loop so that addresses
    // beyond NUM_REGS fall through to the zero default.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        rbusy1 = 1'b0;
        rbusy2 = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
`ifdef V60_REGFILE_BYPASS_EN
            // Forwarded data is masked in reset, where storage
            // is already zero but the write ports may not be idle.
            if (raddr1 == ADDR_W'(i)) begin
                rdata1 = rst_n ? mem_nxt[i] : '0;
                rbusy1 = busy[i] & ~(hit1[i] & ~hitb[i]);
            end
            if (raddr2 == ADDR_W'(i)) begin
                rdata2 = rst_n ? mem_nxt[i] : '0;
                rbusy2 = busy[i] & ~(hit1[i] & ~hitb[i]);
            end
`else
            if (raddr1 == ADDR_W'(i)) begin
                rdata1 = mem[i];
                rbusy1 = busy[i];
            end
            if (raddr2 == ADDR_W'(i)) begin
                rdata2 = mem[i];
                rbusy2 = busy[i];
            end
`endif
        end
    end

endmodule
